// File: rtl/desen_packer.sv
// desen_packer: packs three sampled pattern nibbles into a 12-bit word,
// feeds the last completed word back as prev, and queues words in a
// small first-word-fall-through FIFO drained by a valid/ready consumer.
module desen_packer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample,
  input  logic [3:0]    nibble_in,
  input  logic          flush,
  output logic [11:0]   prev,
  output logic [11:0]   word_data,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [AW:0]   fifo_count,
  output logic [1:0]    nib_cnt,
  output logic          overflow
);

  localparam int unsigned WW = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HAVE1 = 2'd1,
    HAVE2 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      acc_q, acc_d;
  logic            push_c;
  logic [WW-1:0]   push_word_c;

  logic [WW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            pop_c, accept_c;
  logic [AW-1:0]   rd_next_c;
  logic [AW:0]     count_next_c;
  logic [WW-1:0]   head_next_c;

  // State encoding doubles as the held-nibble count.
  assign nib_cnt = 2'(state_q);

  // Packing state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Next state, accumulator and push decision; a new nibble is taken before flush.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    push_c      = 1'b0;
    push_word_c = '0;
    case (state_q)
      IDLE: begin
        if (sample && flush) begin
          push_c      = 1'b1;
          push_word_c = {nibble_in, 8'h00};
        end else if (sample) begin
          state_d = HAVE1;
          acc_d   = {4'h0, nibble_in};
        end
      end
      HAVE1: begin
        if (sample && flush) begin
          push_c      = 1'b1;
          push_word_c = {acc_q[3:0], nibble_in, 4'h0};
          state_d     = IDLE;
          acc_d       = '0;
        end else if (sample) begin
          state_d = HAVE2;
          acc_d   = {acc_q[3:0], nibble_in};
        end else if (flush) begin
          push_c      = 1'b1;
          push_word_c = {acc_q[3:0], 8'h00};
          state_d     = IDLE;
          acc_d       = '0;
        end
      end
      HAVE2: begin
        if (sample) begin
          push_c      = 1'b1;
          push_word_c = {acc_q, nibble_in};
          state_d     = IDLE;
          acc_d       = '0;
        end else if (flush) begin
          push_c      = 1'b1;
          push_word_c = {acc_q, 4'h0};
          state_d     = IDLE;
          acc_d       = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase
  end

  // FIFO control: a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    pop_c     = word_valid & word_ready;
    accept_c  = push_c & ((fifo_count != (AW+1)'(DEPTH)) | pop_c);
    rd_next_c = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    case ({accept_c, pop_c})
      2'b10:   count_next_c = fifo_count + (AW+1)'(1);
      2'b01:   count_next_c = fifo_count - (AW+1)'(1);
      default: count_next_c = fifo_count;
    endcase
    // Bypass the word being written when it becomes the new head.
    head_next_c = (accept_c && (rd_next_c == wr_ptr)) ? push_word_c : mem[rd_next_c];
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (accept_c) mem[wr_ptr] <= push_word_c;
  end

  // FIFO pointers, occupancy, registered head, prev and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      prev       <= '0;
      overflow   <= 1'b0;
    end else begin
      rd_ptr     <= rd_next_c;
      if (accept_c) wr_ptr <= wr_ptr + AW'(1);
      fifo_count <= count_next_c;
      word_valid <= (count_next_c != '0);
      if (count_next_c != '0) word_data <= head_next_c;
      if (push_c) prev <= push_word_c;
      if (push_c && !accept_c) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_desen_packer.sv
// Scoreboard bench for desen_packer: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_desen_packer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample;
  logic [3:0]    nibble_in;
  logic          flush;
  logic [11:0]   prev;
  logic [11:0]   word_data;
  logic          word_valid;
  logic          word_ready;
  logic [AW:0]   fifo_count;
  logic [1:0]    nib_cnt;
  logic          overflow;

  desen_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .sample(sample), .nibble_in(nibble_in), .flush(flush),
    .prev(prev), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .fifo_count(fifo_count), .nib_cnt(nib_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [3:0]  nibs[$];
  logic [11:0] mq[$];
  logic [11:0] sb[$];
  logic [11:0] exp_prev;
  bit          exp_ovf;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    nibs.delete();
    mq.delete();
    sb.delete();
    exp_prev = '0;
    exp_ovf  = 1'b0;
  endtask

  // Monitor: every accepted head word must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst && word_valid && word_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL mon_underrun: got word %0h expected none", word_data);
      end else begin
        check("mon_data", int'(word_data), int'(sb.pop_front()));
      end
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input bit s, input logic [3:0] n, input bit f, input bit r);
    logic [11:0] w;
    bit pop, acc;
    sample = s; nibble_in = n; flush = f; word_ready = r;
    pop = r && (mq.size() > 0);
    if (s) nibs.push_back(n);
    if (pop) void'(mq.pop_front());
    if (nibs.size() == 3 || (f && nibs.size() > 0)) begin
      w = '0;
      for (int i = 0; i < nibs.size(); i++) w[11-4*i -: 4] = nibs[i];
      nibs.delete();
      exp_prev = w;
      acc = (mq.size() < DEPTH);
      if (acc) begin
        mq.push_back(w);
        sb.push_back(w);
      end else begin
        exp_ovf = 1'b1;
      end
    end
    @(posedge clk); #1;
    sample = 1'b0; flush = 1'b0; word_ready = 1'b0; nibble_in = '0;
    check("prev", int'(prev), int'(exp_prev));
    check("fifo_count", int'(fifo_count), mq.size());
    check("word_valid", int'(word_valid), int'(mq.size() != 0));
    check("nib_cnt", int'(nib_cnt), nibs.size());
    check("overflow", int'(overflow), int'(exp_ovf));
    if (mq.size() != 0) check("word_data", int'(word_data), int'(mq[0]));
  endtask

  task automatic word3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2*DEPTH && mq.size() > 0; i++) step(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sample = 1'b0; nibble_in = '0; flush = 1'b0; word_ready = 1'b0;
    model_reset();
    #1;
    check("rst_prev", int'(prev), 0);
    check("rst_valid", int'(word_valid), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_nib", int'(nib_cnt), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_data", int'(word_data), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Basic pack
    word3(4'hA, 4'h5, 4'hC);
    check("a5c_prev", int'(prev), 12'hA5C);
    check("a5c_data", int'(word_data), 12'hA5C);
    drain();

    // Flush after one nibble, then flush in IDLE
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check("flush_prev", int'(prev), 12'h300);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check("idle_flush_cnt", int'(fifo_count), 1);
    drain();

    // Flush coinciding with sample
    step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b1, 1'b0);
    check("sf_prev", int'(prev), 12'h127);
    check("sf_cnt", int'(fifo_count), 1);
    step(1'b1, 4'h9, 1'b1, 1'b0);
    check("sf_idle_prev", int'(prev), 12'h900);
    drain();

    // Overflow: five words into a four-deep FIFO
    for (int k = 1; k <= 5; k++) word3(4'(k), 4'(k), 4'(k));
    check("ovf_cnt", int'(fifo_count), 4);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_prev", int'(prev), 12'h555);
    drain();
    check("ovf_empty", int'(word_valid), 0);

    // Full FIFO with simultaneous pop and push
    do_reset();
    for (int k = 1; k <= 4; k++) word3(4'(k), 4'h0, 4'(k));
    step(1'b1, 4'hE, 1'b0, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b0);
    step(1'b1, 4'hB, 1'b0, 1'b1);
    check("pp_cnt", int'(fifo_count), 4);
    check("pp_ovf", int'(overflow), 0);
    drain();

    // Asynchronous reset mid-word
    for (int k = 6; k <= 8; k++) word3(4'(k), 4'(k), 4'h1);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("ar_prev", int'(prev), 0);
    check("ar_valid", int'(word_valid), 0);
    check("ar_count", int'(fifo_count), 0);
    check("ar_nib", int'(nib_cnt), 0);
    check("ar_data", int'(word_data), 0);
    check("ar_ovf", int'(overflow), 0);
    @(posedge clk); #1 rst = 1'b1;
    word3(4'h4, 4'hB, 4'hF);
    check("ar_word", int'(word_data), 12'h4BF);
    check("ar_cnt1", int'(fifo_count), 1);
    drain();

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step(1'($urandom % 3 != 0), 4'($urandom), 1'($urandom % 5 == 0),
           1'($urandom % 2));
    end
    drain();
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
